multi_digit_updown_counter: RTL and testbench

//  Parametrised multi-digit up/down counter with synchronous load and a digit-carry chain.

---
 rtl/multi_digit_updown_counter.sv | 146 ++++++++++++++
 tb/tb_multi_digit_updown_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multi_digit_updown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multi_digit_updown_counter                                 |
// | Description : N-digit up/down counter (BCD or hex digits) with           |
// |               synchronous clamped load, ripple carry/borrow between      |
// |               digits, terminal-count flag and a time-multiplexed         |
// |               7-segment display scanner.                                 |
// | Options     : define LEADING_ZERO_BLANK_EN to blank leading zero digits  |
// |               (digit 0 is never blanked).                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multi_digit_updown_counter #(
   parameter int NDIGITS  = 2,
   parameter int RADIX    = 16,
   parameter int SCAN_DIV = 4
) (
   input  logic                   clk_2,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   up_dn,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   data_in,
   output logic [4*NDIGITS-1:0]   count,
   output logic                   tc,
   output logic [7:0]             SEG,
   output logic [NDIGITS-1:0]     an
);

   localparam logic [3:0] c_DIGIT_MAX = 4'(RADIX - 1);
   localparam int         c_IDX_W     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int         c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NDIGITS - 1);
   localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

   logic [4*NDIGITS-1:0] r_count;
   logic [c_SCAN_W-1:0]  r_scan_cnt;
   logic [c_IDX_W-1:0]   r_digit_idx;

   logic [4*NDIGITS-1:0] w_step_val;
   logic [4*NDIGITS-1:0] w_load_val;
   logic [3:0]           w_digit;
   logic                 w_ripple;
   logic [3:0]           w_cur_digit;
   logic                 w_cur_blank;
   logic [NDIGITS-1:0]   w_blank_mask;

   // 7-segment decode, segments {dp,g,f,e,d,c,b,a}
   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0: seg_decode = 8'h3F;
         4'h1: seg_decode = 8'h06;
         4'h2: seg_decode = 8'h5B;
         4'h3: seg_decode = 8'h4F;
         4'h4: seg_decode = 8'h66;
         4'h5: seg_decode = 8'h6D;
         4'h6: seg_decode = 8'h7D;
         4'h7: seg_decode = 8'h07;
         4'h8: seg_decode = 8'h7F;
         4'h9: seg_decode = 8'h6F;
         4'hA: seg_decode = 8'h77;
         4'hB: seg_decode = 8'h7C;
         4'hC: seg_decode = 8'h39;
         4'hD: seg_decode = 8'h5E;
         4'hE: seg_decode = 8'h79;
         default: seg_decode = 8'h71;
      endcase
   endfunction

   // Ripple the carry/borrow from digit 0 upward; w_ripple ends high only when
   // every digit sits at its terminal value, which is exactly the wrap condition.
   always_comb begin
      w_ripple   = 1'b1;
      w_digit    = 4'd0;
      w_step_val = r_count;
      w_load_val = '0;
      for (int k = 0; k < NDIGITS; k++) begin
         w_digit = r_count[4*k +: 4];
         w_load_val[4*k +: 4] = (data_in[4*k +: 4] > c_DIGIT_MAX) ? c_DIGIT_MAX
                                                                 : data_in[4*k +: 4];
         if (w_ripple) begin
            if (up_dn)
               w_step_val[4*k +: 4] = (w_digit == 4'd0) ? c_DIGIT_MAX : w_digit - 4'd1;
            else
               w_step_val[4*k +: 4] = (w_digit == c_DIGIT_MAX) ? 4'd0 : w_digit + 4'd1;
         end
         w_ripple = w_ripple & (up_dn ? (w_digit == 4'd0) : (w_digit == c_DIGIT_MAX));
      end
   end

   // Count register: load beats enable, enable beats hold
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (load)
         r_count <= w_load_val;
      else if (en)
         r_count <= w_step_val;
   end

   // Display scan: hold each digit SCAN_DIV cycles, then move to the next one
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= '0;
      end else if (r_scan_cnt == c_SCAN_LAST) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= (r_digit_idx == c_IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
         r_scan_cnt  <= r_scan_cnt + 1'b1;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Mark digits that are zero together with every digit above them
   always_comb begin : g_blank_calc
      logic v_zero_run;
      v_zero_run   = 1'b1;
      w_blank_mask = '0;
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         v_zero_run      = v_zero_run & (r_count[4*k +: 4] == 4'd0);
         w_blank_mask[k] = v_zero_run & (k != 0);
      end
   end
`else
   assign w_blank_mask = '0;
`endif

   // Select the digit currently on the bus and whether it is blanked
   always_comb begin
      w_cur_digit = 4'd0;
      w_cur_blank = 1'b0;
      for (int k = 0; k < NDIGITS; k++) begin
         if (r_digit_idx == c_IDX_W'(k)) begin
            w_cur_digit = r_count[4*k +: 4];
            w_cur_blank = w_blank_mask[k];
         end
      end
   end

   assign count = r_count;
   assign tc    = en & ~load & w_ripple;
   assign an    = NDIGITS'(1) << r_digit_idx;
   assign SEG   = w_cur_blank ? 8'h00 : seg_decode(w_cur_digit);

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_updown_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multi_digit_updown_counter                              |
// | Description : Directed bench: BCD instance (2 digits, scan every 2       |
// |               cycles) plus a hex instance sharing the same stimulus.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multi_digit_updown_counter;

   logic       clk_2;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [7:0] data_in;
   logic [7:0] count;
   logic       tc;
   logic [7:0] SEG;
   logic [1:0] an;
   logic [7:0] count_hex;
   logic       tc_hex;
   logic [7:0] seg_hex;
   logic [1:0] an_hex;

   int checks = 0;
   int errors = 0;

   multi_digit_updown_counter #(.NDIGITS(2), .RADIX(10), .SCAN_DIV(2)) u_bcd (
      .clk_2(clk_2), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .data_in(data_in), .count(count), .tc(tc), .SEG(SEG), .an(an)
   );

   multi_digit_updown_counter #(.NDIGITS(2), .RADIX(16), .SCAN_DIV(2)) u_hex (
      .clk_2(clk_2), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .data_in(data_in), .count(count_hex), .tc(tc_hex), .SEG(seg_hex), .an(an_hex)
   );

   // Free-running clock
   initial begin
      clk_2 = 1'b0;
      forever #5 clk_2 = ~clk_2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       load;
      logic       en;
      logic       up_dn;
      logic [7:0] data;
      logic       exp_tc;
      logic [7:0] exp_count;
   } vec_t;

   vec_t vecs[17];
   logic [7:0] exp_seg;
   logic [1:0] exp_an;

   initial begin
      // load en  up_dn data   tc_before count_after   (BCD)
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h19, 1'b0, 8'h19};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h20};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 8'h99};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h99};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h98};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'hAF, 1'b0, 8'h99};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h37, 1'b0, 8'h37};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h36};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h37};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h5F, 1'b0, 8'h59};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h60};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h09, 1'b0, 8'h09};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h10};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h09};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h09};

      reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; data_in = 8'h00;
      #12;
      chk("reset count", 32'(count), 32'h00);
      chk("reset an", 32'(an), 32'h1);
      chk("reset SEG", 32'(SEG), 32'h3F);
      chk("reset tc idle", 32'(tc), 32'h0);
      en = 1'b1; up_dn = 1'b1;
      #1;
      chk("reset tc down", 32'(tc), 32'h1);
      chk("reset tc down hex", 32'(tc_hex), 32'h1);
      en = 1'b0; up_dn = 1'b0;
      @(negedge clk_2);
      reset = 1'b0;

      // Table-driven sequence on the BCD instance
      for (int i = 0; i < 17; i++) begin
         @(negedge clk_2);
         load = vecs[i].load; en = vecs[i].en; up_dn = vecs[i].up_dn; data_in = vecs[i].data;
         #1;
         chk($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].exp_tc));
         @(posedge clk_2);
         #1;
         chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      end

      // Same stimulus, BCD vs hex radix
      @(negedge clk_2);
      load = 1'b1; en = 1'b0; up_dn = 1'b0; data_in = 8'h19;
      @(negedge clk_2);
      load = 1'b0; en = 1'b1;
      @(posedge clk_2); #1;
      chk("bcd carry", 32'(count), 32'h20);
      chk("hex no carry", 32'(count_hex), 32'h1A);
      @(negedge clk_2);
      load = 1'b1; en = 1'b0; data_in = 8'hFF;
      @(posedge clk_2); #1;
      chk("bcd clamp FF", 32'(count), 32'h99);
      chk("hex load FF", 32'(count_hex), 32'hFF);
      @(negedge clk_2);
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      #1;
      chk("bcd tc at 99", 32'(tc), 32'h1);
      chk("hex tc at FF", 32'(tc_hex), 32'h1);
      @(posedge clk_2); #1;
      chk("bcd wrap up", 32'(count), 32'h00);
      chk("hex wrap up", 32'(count_hex), 32'h00);
      chk("tc after wrap", 32'(tc), 32'h0);
      @(negedge clk_2);
      en = 1'b1; up_dn = 1'b1;
      @(posedge clk_2); #1;
      chk("hex wrap down", 32'(count_hex), 32'hFF);

      // Asynchronous reset in the middle of a count
      @(negedge clk_2);
      load = 1'b1; en = 1'b0; up_dn = 1'b0; data_in = 8'h37;
      @(posedge clk_2); #1;
      load = 1'b0;
      chk("pre-reset count", 32'(count), 32'h37);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset count", 32'(count), 32'h00);
      chk("async reset an", 32'(an), 32'h1);
      chk("async reset SEG", 32'(SEG), 32'h3F);

      // Display scan with count = 05; load happens on the first edge after reset
      load = 1'b1; data_in = 8'h05;
      @(negedge clk_2);
      reset = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk_2); #1;
         if (n == 1) load = 1'b0;
         exp_an = ((n / 2) % 2 == 0) ? 2'b01 : 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
         exp_seg = (exp_an == 2'b01) ? 8'h6D : 8'h00;
`else
         exp_seg = (exp_an == 2'b01) ? 8'h6D : 8'h3F;
`endif
         chk($sformatf("scan%0d an", n), 32'(an), 32'(exp_an));
         chk($sformatf("scan%0d SEG", n), 32'(SEG), 32'(exp_seg));
      end
      chk("scan count held", 32'(count), 32'h05);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
